// File: rtl/cambus_frame_sequencer.sv
// cambus_frame_sequencer
//
// Takes the cambus pixel stream and writes captured lines into a two-bank
// (ping-pong) line buffer for the Nios. Software arms a capture. The block
// waits for the end of vertical blank and writes each active line into the
// current write bank. It then publishes the finished line and swaps banks.
// If the consumer has not released the bank a new line needs, that line is
// dropped and a sticky overrun is raised.
//
// Optional feature: define CAMBUS_SEQ_CONTINUOUS_EN to re-arm automatically
// after every frame. ctl_busy then stays high until ctl_abort. Without the
// macro, each frame needs its own ctl_arm.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   vid_pixel/pixsync/hblank/vblank
//                             cambus stream. The blank flags are valid with
//                             pixsync. The pixel follows one cycle later.
//   ctl_arm, ctl_abort        capture control pulses
//   line_ack, line_ack_bank   consumer releases a bank
//   err_clear                 clears the sticky error flags
//   buf_we/bank/addr/data     line buffer write port, 2 cycles after pixsync
//   line_ready/bank/num/len   published-line pulse and its descriptor
//   ctl_busy                  capture in progress
//   frame_done                pulse at end of frame
//   err_overrun, err_short    sticky: line dropped / frame ended early
module cambus_frame_sequencer #(
    parameter int PIX_W       = 14,
    parameter int LINE_PIXELS = 320,
    parameter int FRAME_LINES = 256,
    parameter int ADDR_W      = 9,
    parameter int LINE_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  vid_pixel,
    input  logic              vid_pixsync,
    input  logic              vid_hblank,
    input  logic              vid_vblank,
    input  logic              ctl_arm,
    input  logic              ctl_abort,
    input  logic              line_ack,
    input  logic              line_ack_bank,
    input  logic              err_clear,
    output logic              buf_we,
    output logic              buf_bank,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [PIX_W-1:0]  buf_data,
    output logic              line_ready,
    output logic              line_bank,
    output logic [LINE_W-1:0] line_num,
    output logic [ADDR_W:0]   line_len,
    output logic              ctl_busy,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              err_short
);

    localparam logic [ADDR_W:0]   MAX_PIX  = (ADDR_W+1)'(LINE_PIXELS);
    localparam logic [LINE_W-1:0] LAST_CNT = LINE_W'(FRAME_LINES);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VB, S_WAIT_LINE, S_ACTIVE, S_DONE
    } state_t;

    state_t              state;
    logic                prev_hb, prev_vb;   // blank flags at last pixsync
    logic                wbank;              // bank the next line goes to
    logic [1:0]          bank_full;
    logic [LINE_W-1:0]   line_cnt;           // lines started this frame
    logic [LINE_W-1:0]   cur_line;
    logic [ADDR_W:0]     pix_cnt;            // saturates at LINE_PIXELS
    logic                drop;               // current line is being dropped
    // stage 1 of the write pipe; the pixel itself arrives a cycle later
    logic                pend_we;
    logic                pend_bank;
    logic [ADDR_W-1:0]   pend_addr;

    logic hb_fall, hb_rise, vb_fall, line_start, start_drop, act_end;
    logic pub_fire, wr_fire, overrun_set, short_set;
    logic [ADDR_W:0] wr_idx;
    logic [1:0]      ack_mask, pub_mask;

    always_comb begin
        hb_fall     = vid_pixsync & prev_hb & ~vid_hblank;
        hb_rise     = vid_pixsync & ~prev_hb & vid_hblank;
        vb_fall     = vid_pixsync & prev_vb & ~vid_vblank;
        // vblank wins over a line start seen on the same sample
        line_start  = (state == S_WAIT_LINE) & hb_fall & ~vid_vblank;
        start_drop  = bank_full[wbank];
        act_end     = (state == S_ACTIVE) & vid_pixsync & (vid_vblank | hb_rise);
        pub_fire    = act_end & ~drop & (pix_cnt != '0) & ~ctl_abort;
        wr_idx      = line_start ? '0 : pix_cnt;
        wr_fire     = ~ctl_abort & vid_pixsync & ~vid_hblank & ~vid_vblank &
                      ((line_start & ~start_drop) | ((state == S_ACTIVE) & ~drop)) &
                      (wr_idx < MAX_PIX);
        overrun_set = ~ctl_abort & line_start & start_drop;
        short_set   = ~ctl_abort & vid_pixsync & vid_vblank &
                      ((state == S_WAIT_LINE) | (state == S_ACTIVE));
        ack_mask    = line_ack ? (2'b01 << line_ack_bank) : 2'b00;
        // publish is applied after the ack so it wins on the same bank
        pub_mask    = pub_fire ? (2'b01 << wbank) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            prev_hb     <= 1'b0;
            prev_vb     <= 1'b0;
            wbank       <= 1'b0;
            bank_full   <= 2'b00;
            line_cnt    <= '0;
            cur_line    <= '0;
            pix_cnt     <= '0;
            drop        <= 1'b0;
            pend_we     <= 1'b0;
            pend_bank   <= 1'b0;
            pend_addr   <= '0;
            buf_we      <= 1'b0;
            buf_bank    <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            line_ready  <= 1'b0;
            line_bank   <= 1'b0;
            line_num    <= '0;
            line_len    <= '0;
            ctl_busy    <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            line_ready <= 1'b0;
            frame_done <= 1'b0;

            if (vid_pixsync) begin
                prev_hb <= vid_hblank;
                prev_vb <= vid_vblank;
            end

            // write pipe: address latched on the pixsync, data on the next cycle
            pend_we <= wr_fire;
            if (wr_fire) begin
                pend_bank <= wbank;
                pend_addr <= wr_idx[ADDR_W-1:0];
            end
            buf_we <= pend_we & ~ctl_abort;
            if (pend_we) begin
                buf_bank <= pend_bank;
                buf_addr <= pend_addr;
                buf_data <= vid_pixel;
            end

            bank_full   <= (bank_full & ~ack_mask) | pub_mask;
            err_overrun <= overrun_set | (err_overrun & ~err_clear);
            err_short   <= short_set   | (err_short   & ~err_clear);

            if (pub_fire) begin
                line_ready <= 1'b1;
                line_bank  <= wbank;
                line_num   <= cur_line;
                line_len   <= pix_cnt;
                wbank      <= ~wbank;
            end

            if (ctl_abort) begin
                state    <= S_IDLE;
                ctl_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ctl_arm) begin
                            state    <= S_WAIT_VB;
                            ctl_busy <= 1'b1;
                            line_cnt <= '0;
                        end
                    end
                    S_WAIT_VB: begin
                        if (vb_fall) state <= S_WAIT_LINE;
                    end
                    S_WAIT_LINE: begin
                        if (vid_pixsync && vid_vblank) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else if (line_start) begin
                            // a dropped line still counts toward the frame
                            state    <= S_ACTIVE;
                            drop     <= start_drop;
                            cur_line <= line_cnt;
                            line_cnt <= line_cnt + 1'b1;
                            pix_cnt  <= (ADDR_W+1)'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (vid_pixsync && vid_vblank) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else if (hb_rise) begin
                            if (line_cnt == LAST_CNT) begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                            end else begin
                                state <= S_WAIT_LINE;
                            end
                        end else if (vid_pixsync && !vid_hblank && pix_cnt < MAX_PIX) begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
`ifdef CAMBUS_SEQ_CONTINUOUS_EN
                        state    <= S_WAIT_VB;
                        line_cnt <= '0;
`else
                        state    <= S_IDLE;
                        ctl_busy <= 1'b0;
`endif
                    end
                    default: begin
                        state    <= S_IDLE;
                        ctl_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cambus_frame_sequencer.sv
// Randomized scoreboard bench for cambus_frame_sequencer.
// The stimulus side builds frames line by line. A small line-level model
// (bank flags, write bank, sticky errors) predicts the buffer writes and the
// published lines. Those predictions go into queues that a negedge monitor
// drains when the DUT presents buf_we / line_ready.
module tb_cambus_frame_sequencer;
    localparam int PIX_W = 14, LP = 320, FL = 256, AW = 9, LW = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [PIX_W-1:0] vid_pixel;
    logic             vid_pixsync, vid_hblank, vid_vblank;
    logic             ctl_arm, ctl_abort, line_ack, line_ack_bank, err_clear;
    logic             buf_we, buf_bank, line_ready, line_bank;
    logic [AW-1:0]    buf_addr;
    logic [PIX_W-1:0] buf_data;
    logic [LW-1:0]    line_num;
    logic [AW:0]      line_len;
    logic             ctl_busy, frame_done, err_overrun, err_short;

    cambus_frame_sequencer #(.PIX_W(PIX_W), .LINE_PIXELS(LP), .FRAME_LINES(FL),
                             .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst), .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync),
        .vid_hblank(vid_hblank), .vid_vblank(vid_vblank), .ctl_arm(ctl_arm),
        .ctl_abort(ctl_abort), .line_ack(line_ack), .line_ack_bank(line_ack_bank),
        .err_clear(err_clear), .buf_we(buf_we), .buf_bank(buf_bank),
        .buf_addr(buf_addr), .buf_data(buf_data), .line_ready(line_ready),
        .line_bank(line_bank), .line_num(line_num), .line_len(line_len),
        .ctl_busy(ctl_busy), .frame_done(frame_done), .err_overrun(err_overrun),
        .err_short(err_short));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct { int bank; int addr; int data; int cyc; } wr_t;
    typedef struct { int bank; int num; int len; } pub_t;
    wr_t wq[$];
    pub_t pq[$];
    int fd_seen = 0, fd_exp = 0;
    int last_num = -1;

    // line-level reference state
    int m_full[2];
    int m_wbank, m_ovr, m_short;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    wr_t  mw;
    pub_t mp;
    always @(negedge clk) begin
        if (buf_we) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: addr %0d data %0d, none expected", buf_addr, buf_data);
            end else begin
                mw = wq.pop_front();
                chk("wr_bank", int'(buf_bank), mw.bank);
                chk("wr_addr", int'(buf_addr), mw.addr);
                chk("wr_data", int'(buf_data), mw.data);
                chk("wr_latency", cyc, mw.cyc);
            end
        end
        if (line_ready) begin
            last_num = int'(line_num);
            if (pq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_line_ready: num %0d, none expected", line_num);
            end else begin
                mp = pq.pop_front();
                chk("pub_bank", int'(line_bank), mp.bank);
                chk("pub_num", int'(line_num), mp.num);
                chk("pub_len", int'(line_len), mp.len);
            end
        end
        if (frame_done) fd_seen++;
    end

    // one pixsync sample plus the following pixel cycle; blank inputs are
    // scrambled outside pixsync because the DUT should ignore them there
    task automatic sample(input bit hb, input bit vb, input int pix,
                          input bit wr, input int wbank, input int waddr);
        @(negedge clk);
        vid_pixsync = 1'b1; vid_hblank = hb; vid_vblank = vb;
        vid_pixel = PIX_W'($urandom);
        if (wr) wq.push_back('{wbank, waddr, pix, cyc + 2});
        @(negedge clk);
        vid_pixsync = 1'b0; vid_pixel = PIX_W'(pix);
        vid_hblank = 1'($urandom); vid_vblank = 1'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            vid_pixel = PIX_W'($urandom);
        end
    endtask

    task automatic pulse_arm();
        @(negedge clk); ctl_arm = 1'b1;
        @(negedge clk); ctl_arm = 1'b0;
    endtask

    task automatic ack(input int b);
        @(negedge clk); line_ack = 1'b1; line_ack_bank = 1'(b); m_full[b] = 0;
        @(negedge clk); line_ack = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk); err_clear = 1'b1; m_ovr = 0; m_short = 0;
        @(negedge clk); err_clear = 1'b0;
    endtask

    task automatic vblank_pre();
        sample(1, 1, 0, 0, 0, 0);
        sample(1, 1, 0, 0, 0, 0);
        sample(1, 0, 0, 0, 0, 0);
    endtask

    // pixels of one line; returns the bank used and whether it was dropped
    task automatic line_pixels(input int n, output bit drop, output int b);
        int pix;
        drop = (m_full[m_wbank] != 0);
        b = m_wbank;
        if (drop) m_ovr = 1;
        for (int i = 0; i < n; i++) begin
            pix = int'($urandom_range(0, 16383));
            sample(0, 0, pix, !drop && i < LP, b, i);
        end
    endtask

    task automatic send_line(input int n, input int idx, input bit do_ack);
        bit drop;
        int b;
        line_pixels(n, drop, b);
        if (!drop) pq.push_back('{b, idx, (n < LP) ? n : LP});
        sample(1, 0, 0, 0, 0, 0);
        if (!drop) begin
            m_full[b] = 1;
            m_wbank ^= 1;
            if (do_ack) ack(b);
        end
    endtask

    task automatic frame(input int nlines, input int ack_from, input int big_line);
        pulse_arm();
        vblank_pre();
        for (int l = 0; l < nlines; l++)
            send_line((l == big_line) ? 330 : int'($urandom_range(1, 6)), l, l >= ack_from);
        if (nlines < FL) begin
            sample(1, 1, 0, 0, 0, 0);
            m_short = 1;
        end
        fd_exp++;
        sample(1, 1, 0, 0, 0, 0);
        sample(1, 1, 0, 0, 0, 0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_frame_done"}, fd_seen, fd_exp);
        chk({tag, "_err_overrun"}, int'(err_overrun), m_ovr);
        chk({tag, "_err_short"}, int'(err_short), m_short);
        chk({tag, "_ctl_busy"}, int'(ctl_busy), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_buf_we"}, int'(buf_we), 0);
        chk({tag, "_buf_addr"}, int'(buf_addr), 0);
        chk({tag, "_buf_data"}, int'(buf_data), 0);
        chk({tag, "_line_ready"}, int'(line_ready), 0);
        chk({tag, "_line_len"}, int'(line_len), 0);
        chk({tag, "_line_num"}, int'(line_num), 0);
        chk({tag, "_ctl_busy"}, int'(ctl_busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_err_overrun"}, int'(err_overrun), 0);
        chk({tag, "_err_short"}, int'(err_short), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit drop;
        int b;
        rst = 1'b1; vid_pixel = '0; vid_pixsync = 1'b0; vid_hblank = 1'b0;
        vid_vblank = 1'b0; ctl_arm = 1'b0; ctl_abort = 1'b0; line_ack = 1'b0;
        line_ack_bank = 1'b0; err_clear = 1'b0;
        m_full[0] = 0; m_full[1] = 0; m_wbank = 0; m_ovr = 0; m_short = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // two full frames, every line acked, one over-long line in each
        frame(FL, 0, 3);
        check_status("frame1");
        frame(FL, 0, 200);
        check_status("frame2");

        // consumer stalls: lines 0,1 fill both banks, later lines drop
        frame(5, FL, -1);
        check_status("overrun");
        clear_errs();
        check_status("overrun_clr");
        ack(0); ack(1);

        // early vblank after 100 complete lines
        frame(100, 0, -1);
        check_status("short100");
        chk("short100_last_num", last_num, 99);
        clear_errs();

        // abort in the middle of line 50
        pulse_arm();
        vblank_pre();
        for (int l = 0; l < 50; l++) send_line(int'($urandom_range(1, 4)), l, 1);
        line_pixels(3, drop, b);
        repeat (2) @(negedge clk);
        ctl_abort = 1'b1;
        @(negedge clk);
        ctl_abort = 1'b0;
        chk("abort_busy", int'(ctl_busy), 0);
        repeat (4) @(negedge clk);
        check_status("abort");

        // vblank arrives while a line is active: partial line is published
        pulse_arm();
        vblank_pre();
        send_line(4, 0, 1);
        send_line(2, 1, 1);
        line_pixels(4, drop, b);
        if (!drop) pq.push_back('{b, 2, 4});
        sample(1, 1, 0, 0, 0, 0);
        if (!drop) begin m_full[b] = 1; m_wbank ^= 1; ack(b); end
        m_short = 1;
        fd_exp++;
        sample(1, 1, 0, 0, 0, 0);
        check_status("partial");

        // reset mid-line with err_short still set
        pulse_arm();
        vblank_pre();
        send_line(3, 0, 0);
        line_pixels(2, drop, b);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        m_full[0] = 0; m_full[1] = 0; m_wbank = 0; m_ovr = 0; m_short = 0;

        // after reset the write bank starts at 0 and both banks are free
        frame(3, 2, -1);
        check_status("postrst");

        repeat (4) @(negedge clk);
        chk("wq_drained", wq.size(), 0);
        chk("pq_drained", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
